// File: rtl/wb_drain_pkg.sv
// Shared definitions for the write-buffer drain stage.
//   wb_drain_state_t : drain FSM state encoding
//   WB_DW / WB_BEATW : buffer word width and DDR beat width
//   WB_WL_DEFAULT    : default write latency (WrStart to first beat)
//   WB_LENW_DEFAULT  : default width of the burst-length field
package wb_drain_pkg;

  localparam int unsigned WB_DW           = 144;
  localparam int unsigned WB_BEATW        = 72;
  localparam int unsigned WB_WL_DEFAULT   = 4;
  localparam int unsigned WB_LENW_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    LO,
    HI
  } wb_drain_state_t;

endpackage

// File: rtl/wb_drain.sv
// Drain stage between the write buffer (FWFT read side) and the DDR data-path.
// A write command pops WrLen words and emits each as two half-width beats, low
// half first, starting exactly WL cycles after WrStart. If the buffer runs dry,
// the missing beats are sent as zero and Underrun is flagged. Burst timing is
// never stretched.
//
// Ports:
//   Rclk, Reset_n : clock, asynchronous active-low reset
//   WrStart, WrLen: write command strobe and burst length in words (0 = 2**LENW)
//   Busy          : transfer in progress; WrStart is ignored while high
//   MD, Empty     : buffer head word and empty flag
//   RDen          : buffer pop (combinational)
//   DQ, DQvalid   : registered beat to the DDR data-path
//   Done          : pulse coincident with the final beat
//   Underrun      : sticky, set when a word was needed and the buffer was empty
//   ClrErr        : clears Underrun (a simultaneous new underrun wins)
module wb_drain
  import wb_drain_pkg::*;
#(
  parameter int unsigned WL   = WB_WL_DEFAULT,
  parameter int unsigned LENW = WB_LENW_DEFAULT,
  parameter int unsigned DW   = WB_DW
) (
  input  logic            Rclk,
  input  logic            Reset_n,
  input  logic            WrStart,
  input  logic [LENW-1:0] WrLen,
  output logic            Busy,
  input  logic [DW-1:0]   MD,
  input  logic            Empty,
  output logic            RDen,
  output logic [DW/2-1:0] DQ,
  output logic            DQvalid,
  output logic            Done,
  output logic            Underrun,
  input  logic            ClrErr
);

  localparam int unsigned BW = DW / 2;

  // WAIT spans WL-2 cycles; the counter counts down to zero, so load WL-3.
  localparam logic [3:0] WAIT_LOAD = (WL > 2) ? 4'(WL - 3) : 4'd0;

  wb_drain_state_t state_q, state_d;
  logic [LENW-1:0] rem_q, rem_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic [BW-1:0]   hi_q, hi_d;
  logic [BW-1:0]   dq_q, dq_d;
  logic            dqv_q, dqv_d;
  logic            done_q, done_d;
  logic            urun_q, urun_d;
  logic            pop;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    wcnt_d  = wcnt_q;
    hi_d    = hi_q;
    dq_d    = '0;
    dqv_d   = 1'b0;
    done_d  = 1'b0;
    urun_d  = urun_q;
    pop     = 1'b0;

    if (ClrErr) begin
      urun_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (WrStart) begin
          rem_d = WrLen;
          if (WL == 2) begin
            state_d = LO;
          end else begin
            wcnt_d  = WAIT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (wcnt_q == 4'd0) begin
          state_d = LO;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      LO: begin
        dqv_d   = 1'b1;
        state_d = HI;
        if (!Empty) begin
          pop  = 1'b1;
          dq_d = MD[BW-1:0];
          hi_d = MD[DW-1:BW];
        end else begin
          // Keep the beat slot but send zeros; set overrides a same-cycle clear.
          hi_d   = '0;
          urun_d = 1'b1;
        end
      end
      HI: begin
        dqv_d = 1'b1;
        dq_d  = hi_q;
        rem_d = rem_q - 1'b1;
        // rem_q of 0 means a full 2**LENW burst, so it must wrap, not finish.
        if (rem_q == LENW'(1)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = LO;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Rclk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      wcnt_q  <= '0;
      hi_q    <= '0;
      dq_q    <= '0;
      dqv_q   <= 1'b0;
      done_q  <= 1'b0;
      urun_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      wcnt_q  <= wcnt_d;
      hi_q    <= hi_d;
      dq_q    <= dq_d;
      dqv_q   <= dqv_d;
      done_q  <= done_d;
      urun_q  <= urun_d;
    end
  end

  assign Busy     = (state_q != IDLE);
  assign RDen     = pop;
  assign DQ       = dq_q;
  assign DQvalid  = dqv_q;
  assign Done     = done_q;
  assign Underrun = urun_q;

endmodule

// File: tb/tb_wb_drain.sv
// Randomized, scoreboarded bench for wb_drain. A queue models the write
// buffer; each accepted command pushes its expected beats (cycle, data, done)
// and a separate negedge monitor pops and compares whatever the DUT presents.
module tb_wb_drain;
  import wb_drain_pkg::*;

  localparam int unsigned WL   = 4;
  localparam int unsigned LENW = 4;
  localparam int unsigned DW   = WB_DW;
  localparam int unsigned BW   = WB_BEATW;

  logic            Rclk    = 1'b0;
  logic            Reset_n = 1'b0;
  logic            WrStart = 1'b0;
  logic [LENW-1:0] WrLen   = '0;
  logic            ClrErr  = 1'b0;
  logic [DW-1:0]   MD      = '0;
  logic            Empty   = 1'b1;
  logic            Busy, RDen, DQvalid, Done, Underrun;
  logic [BW-1:0]   DQ;

  // Second instance for the WL=2 corner, fed from an always-full buffer.
  logic            WrStart2 = 1'b0;
  logic [LENW-1:0] WrLen2   = 4'd1;
  logic [DW-1:0]   MD2      = '0;
  logic            Empty2   = 1'b0;
  logic            ClrErr2  = 1'b0;
  logic            Busy2, RDen2, DQvalid2, Done2, Underrun2;
  logic [BW-1:0]   DQ2;

  always #5 Rclk = ~Rclk;

  wb_drain #(.WL(WL), .LENW(LENW), .DW(DW)) u_dut (
    .Rclk(Rclk), .Reset_n(Reset_n), .WrStart(WrStart), .WrLen(WrLen), .Busy(Busy),
    .MD(MD), .Empty(Empty), .RDen(RDen), .DQ(DQ), .DQvalid(DQvalid), .Done(Done),
    .Underrun(Underrun), .ClrErr(ClrErr)
  );

  wb_drain #(.WL(2), .LENW(LENW), .DW(DW)) u_dut_wl2 (
    .Rclk(Rclk), .Reset_n(Reset_n), .WrStart(WrStart2), .WrLen(WrLen2), .Busy(Busy2),
    .MD(MD2), .Empty(Empty2), .RDen(RDen2), .DQ(DQ2), .DQvalid(DQvalid2), .Done(Done2),
    .Underrun(Underrun2), .ClrErr(ClrErr2)
  );

  typedef struct {
    int            cyc;
    logic [BW-1:0] data;
    logic          done;
  } beat_t;

  beat_t         sb[$];
  logic [DW-1:0] wbuf[$];
  bit            ur_set[int];
  int            cyc       = 0;
  bit            exp_ur    = 1'b0;
  int            busy_from = -1;
  int            busy_to   = -2;
  bit            rden_seen = 1'b0;
  int            pops      = 0;
  int            exp_pops  = 0;
  int            checks    = 0;
  int            errors    = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic fail(input string nm, input int a, input int b);
    checks++;
    errors++;
    $display("FAIL %s cyc=%0d got %0d expected %0d", nm, cyc, a, b);
  endtask

  function automatic bit model_busy(input int c);
    return (c >= busy_from) && (c <= busy_to);
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  // Buffer presents its head; garbage on MD while empty must never reach DQ.
  task automatic refresh();
    Empty = (wbuf.size() == 0);
    MD    = Empty ? rand_word() : wbuf[0];
  endtask

  task automatic tick();
    @(posedge Rclk);
    #1;
    if (rden_seen) begin
      if (wbuf.size() != 0) void'(wbuf.pop_front());
      pops++;
      rden_seen = 1'b0;
    end
    refresh();
  endtask

  // Cycle counter and Underrun model, advanced at each active edge.
  initial forever begin
    @(posedge Rclk);
    if (!Reset_n) exp_ur = 1'b0;
    else if (ur_set.exists(cyc)) exp_ur = 1'b1;
    else if (ClrErr) exp_ur = 1'b0;
    cyc++;
  end

  // Monitor: compares everything the DUT presents, mid-cycle.
  initial forever begin
    beat_t e;
    @(negedge Rclk);
    if (!Reset_n) begin
      rden_seen = 1'b0;
    end else begin
      while (sb.size() != 0 && sb[0].cyc < cyc) begin
        fail("beat_missing", 0, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (DQvalid) begin
        if (sb.size() == 0 || sb[0].cyc != cyc) begin
          fail("beat_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("dq", DW'(DQ), DW'(e.data));
          chk("done", DW'(Done), DW'(e.done));
        end
      end else begin
        if (sb.size() != 0 && sb[0].cyc == cyc) begin
          fail("beat_missing", 0, cyc);
          void'(sb.pop_front());
        end
        chk("done_idle", DW'(Done), '0);
      end
      chk("busy", DW'(Busy), DW'(model_busy(cyc)));
      chk("underrun", DW'(Underrun), DW'(exp_ur));
      chk("rden_on_empty", DW'(RDen & Empty), '0);
      rden_seen = RDen;
    end
  end

  // Drive one WrStart cycle; the model alone decides whether it is accepted.
  task automatic start(input logic [LENW-1:0] len);
    int            n;
    int            c;
    int            have;
    logic [DW-1:0] w;
    beat_t         e;
    n    = (len == 0) ? (1 << LENW) : int'(len);
    c    = cyc;
    have = wbuf.size();
    WrStart = 1'b1;
    WrLen   = len;
    if (!model_busy(c)) begin
      for (int i = 0; i < n; i++) begin
        if (i < have) begin
          w = wbuf[i];
        end else begin
          w = '0;
          ur_set[c + WL - 1 + 2 * i] = 1'b1;
        end
        e.cyc = c + WL + 2 * i;     e.data = w[BW-1:0];  e.done = 1'b0;
        sb.push_back(e);
        e.cyc = c + WL + 2 * i + 1; e.data = w[DW-1:BW]; e.done = (i == n - 1);
        sb.push_back(e);
      end
      exp_pops += (n < have) ? n : have;
      busy_from = c + 1;
      busy_to   = c + WL + 2 * n - 2;
    end
    tick();
    WrStart = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd_clr);
    int n;
    n = 0;
    while ((sb.size() != 0 || model_busy(cyc)) && n < 300) begin
      ClrErr = rnd_clr && ($urandom_range(0, 3) == 0);
      tick();
      n++;
    end
    ClrErr = 1'b0;
    if (n >= 300) fail("idle_timeout", n, 300);
    tick();
    tick();
  endtask

  task automatic push_words(input int k);
    for (int j = 0; j < k; j++) wbuf.push_back(rand_word());
    refresh();
  endtask

  initial begin
    logic [DW-1:0] a;
    int            c;
    int            len;
    int            n;
    int            have;

    refresh();
    #2;
    chk("rst_dqvalid", DW'(DQvalid), '0);
    chk("rst_dq", DW'(DQ), '0);
    chk("rst_busy", DW'(Busy), '0);
    chk("rst_done", DW'(Done), '0);
    chk("rst_underrun", DW'(Underrun), '0);
    chk("rst_rden", DW'(RDen), '0);
    tick();
    tick();
    Reset_n = 1'b1;
    tick();

    // Basic two-word burst.
    a = rand_word();
    a[7:0] = 8'h11;
    a[BW+7:BW] = 8'h22;
    wbuf.push_back(a);
    push_words(1);
    start(4'd2);
    wait_idle(1'b0);
    chk("pops_basic", DW'(pops), DW'(exp_pops));

    // WrLen=0 means a full 16-word burst.
    push_words(16);
    start(4'd0);
    wait_idle(1'b0);
    chk("pops_wrap", DW'(pops), DW'(exp_pops));

    // Underrun: one word for a two-word burst; flag holds until cleared.
    push_words(1);
    start(4'd2);
    wait_idle(1'b0);
    repeat (3) tick();
    ClrErr = 1'b1;
    tick();
    ClrErr = 1'b0;
    tick();
    chk("pops_underrun", DW'(pops), DW'(exp_pops));

    // ClrErr in the same cycle as a fresh underrun: set wins.
    c = cyc;
    start(4'd1);
    while (cyc < c + WL - 1) tick();
    ClrErr = 1'b1;
    tick();
    ClrErr = 1'b0;
    wait_idle(1'b0);

    // Back-to-back, with a WrStart while busy that must be ignored.
    push_words(4);
    c = cyc;
    start(4'd2);
    start(4'd1);
    while (cyc < c + WL + 3) tick();
    start(4'd2);
    wait_idle(1'b0);
    chk("pops_b2b", DW'(pops), DW'(exp_pops));

    // Reset during beat 1: outputs drop immediately, unpopped words survive.
    push_words(3);
    c = cyc;
    start(4'd2);
    while (cyc < c + WL + 1) tick();
    #1;
    Reset_n = 1'b0;
    #1;
    chk("arst_dqvalid", DW'(DQvalid), '0);
    chk("arst_dq", DW'(DQ), '0);
    chk("arst_busy", DW'(Busy), '0);
    chk("arst_done", DW'(Done), '0);
    chk("arst_underrun", DW'(Underrun), '0);
    sb.delete();
    ur_set.delete();
    busy_from = -1;
    busy_to   = -2;
    exp_ur    = 1'b0;
    exp_pops -= 1;
    tick();
    Reset_n = 1'b1;
    tick();
    start(4'd1);
    wait_idle(1'b0);
    chk("pops_reset", DW'(pops), DW'(exp_pops));

    // Randomized bursts, occasional underruns, stray WrStarts and ClrErr.
    for (int it = 0; it < 25; it++) begin
      len  = $urandom_range(0, 15);
      n    = (len == 0) ? 16 : len;
      have = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n) : n + $urandom_range(0, 2);
      push_words(have);
      repeat ($urandom_range(0, 3)) tick();
      start(LENW'(len));
      if ($urandom_range(0, 1) == 1) start(LENW'($urandom_range(1, 15)));
      wait_idle(1'b1);
    end
    chk("pops_random", DW'(pops), DW'(exp_pops));

    // WL=2 corner: first beat two cycles after WrStart, no WAIT state.
    MD2 = rand_word();
    WrStart2 = 1'b1;
    tick();
    WrStart2 = 1'b0;
    chk("wl2_c1_dqvalid", DW'(DQvalid2), '0);
    chk("wl2_c1_rden", DW'(RDen2), DW'(1'b1));
    chk("wl2_c1_busy", DW'(Busy2), DW'(1'b1));
    tick();
    chk("wl2_c2_dqvalid", DW'(DQvalid2), DW'(1'b1));
    chk("wl2_c2_dq", DW'(DQ2), DW'(MD2[BW-1:0]));
    chk("wl2_c2_done", DW'(Done2), '0);
    tick();
    chk("wl2_c3_dq", DW'(DQ2), DW'(MD2[DW-1:BW]));
    chk("wl2_c3_done", DW'(Done2), DW'(1'b1));
    chk("wl2_c3_busy", DW'(Busy2), '0);
    tick();
    chk("wl2_c4_dqvalid", DW'(DQvalid2), '0);
    chk("wl2_underrun", DW'(Underrun2), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
